// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with press/release debounce and ack handshake
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 1000,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       RST,
    input  logic [3:0] RowIn,
    output logic [3:0] ColOut,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_held
);

    localparam int SW = $clog2(SCAN_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DB_FULL   = DW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {SCAN, DEBOUNCE_P, VALID, WAIT_REL} state_t;

    state_t        state;
    logic [1:0]    col;
    logic [3:0]    row_pat;
    logic [SW-1:0] scan_cnt;
    logic [DW-1:0] db_cnt;

    // Multi-row presses resolve to the lowest-index row.
    function automatic logic [1:0] low_row(input logic [3:0] pat);
        if (!pat[0])      return 2'd0;
        else if (!pat[1]) return 2'd1;
        else if (!pat[2]) return 2'd2;
        else              return 2'd3;
    endfunction

    function automatic logic [3:0] strobe(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= SCAN;
            col       <= 2'd0;
            ColOut    <= 4'b1110;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            key_code  <= 4'd0;
            row_pat   <= 4'hF;
            scan_cnt  <= '0;
            db_cnt    <= '0;
        end else begin
            case (state)
                SCAN: begin
                    if (scan_cnt == SCAN_LAST) begin
                        scan_cnt <= '0;
                        if (RowIn == 4'hF) begin
                            col    <= col + 2'd1;
                            ColOut <= strobe(col + 2'd1);
                        end else begin
                            row_pat <= RowIn;
                            db_cnt  <= '0;
                            state   <= DEBOUNCE_P;
                        end
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
                DEBOUNCE_P: begin
                    // The sampled pattern must survive a full debounce window plus one confirm cycle.
                    if (RowIn != row_pat) begin
                        state    <= SCAN;
                        col      <= col + 2'd1;
                        ColOut   <= strobe(col + 2'd1);
                        scan_cnt <= '0;
                        db_cnt   <= '0;
                    end else if (db_cnt == DB_FULL) begin
                        state     <= VALID;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        key_code  <= {low_row(row_pat), col};
                        db_cnt    <= '0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                VALID: begin
                    if (key_ack) begin
                        state     <= WAIT_REL;
                        key_valid <= 1'b0;
                        db_cnt    <= '0;
                    end
                end
                WAIT_REL: begin
                    if (RowIn == 4'hF) begin
                        if (db_cnt == DB_LAST) begin
                            state    <= SCAN;
                            key_held <= 1'b0;
                            col      <= col + 2'd1;
                            ColOut   <= strobe(col + 2'd1);
                            scan_cnt <= '0;
                            db_cnt   <= '0;
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end else begin
                        db_cnt <= '0;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed scoreboard bench for keypad_scanner
module tb_keypad_scanner;

    localparam int SCAN = 4;
    localparam int DEB  = 8;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] RowIn;
    logic [3:0] ColOut;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack = 1'b0;
    logic       key_held;

    keypad_scanner #(.SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk(clk), .RST(RST), .RowIn(RowIn), .ColOut(ColOut),
        .key_code(key_code), .key_valid(key_valid), .key_ack(key_ack), .key_held(key_held)
    );

    always #5 clk = ~clk;

    logic press_en  = 1'b0;
    logic bounce_en = 1'b0;
    int   press_row = 0;
    int   press_col = 0;

    // Keypad model: a pressed switch pulls its row low only while its column is strobed.
    always_comb begin
        RowIn = 4'hF;
        if (bounce_en)
            RowIn = 4'b1110;
        else if (press_en && ColOut[press_col] == 1'b0)
            RowIn[press_row] = 1'b0;
    end

    int         passed = 0;
    int         total  = 0;
    int         fails  = 0;
    int         pulses = 0;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;
    logic       prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid && !prev_valid) begin
            pulses++;
            if (exp_q.size() == 0) begin
                check("unexpected_key_valid", 32'd1, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("key_code", key_code, mon_exp);
            end
        end
        prev_valid = key_valid;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step(2);
        RST = 1'b0;
    endtask

    task automatic press(input int r, input int c);
        press_row = r;
        press_col = c;
        press_en  = 1'b1;
        exp_q.push_back(4'(r * 4 + c));
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!key_valid && n < 300) begin
            step(1);
            n++;
        end
        check(tag, key_valid, 1);
    endtask

    task automatic wait_held_low(input string tag);
        int n = 0;
        while (key_held && n < 300) begin
            step(1);
            n++;
        end
        check(tag, key_held, 0);
    endtask

    task automatic do_ack();
        key_ack = 1'b1;
        step(1);
        check("ack_drops_valid", key_valid, 0);
        key_ack = 1'b0;
    endtask

    int seq_r[4] = '{0, 2, 1, 3};
    int seq_c[4] = '{2, 3, 0, 0};
    int base_pulses;

    initial begin
        // reset state and idle column rotation
        step(2);
        check("rst_colout", ColOut, 4'b1110);
        check("rst_valid", key_valid, 0);
        check("rst_held", key_held, 0);
        check("rst_code", key_code, 0);
        RST = 1'b0;
        step(SCAN); check("scan_col1", ColOut, 4'b1101);
        step(SCAN); check("scan_col2", ColOut, 4'b1011);
        step(SCAN); check("scan_col3", ColOut, 4'b0111);
        step(SCAN); check("scan_wrap", ColOut, 4'b1110);

        // single press of index 2, exact latency
        do_reset();
        press(0, 2);
        step(20); check("latency_early", key_valid, 0);
        step(1);  check("latency_exact", key_valid, 1);
        check("held_on_accept", key_held, 1);
        do_ack();
        press_en = 1'b0;
        step(DEB - 1); check("held_before_release_db", key_held, 1);
        step(1);       check("held_drop_after_release_db", key_held, 0);
        check("col_advanced_after_release", ColOut, 4'b0111);

        // sequence 2,11,4,12 with long holds
        base_pulses = pulses;
        for (int k = 0; k < 4; k++) begin
            press(seq_r[k], seq_c[k]);
            wait_valid("seq_valid");
            step(40); check("valid_until_ack", key_valid, 1);
            do_ack();
            step(40); check("no_repeat_while_held", key_valid, 0);
            press_en = 1'b0;
            wait_held_low("seq_release");
        end
        check("seq_pulse_count", pulses - base_pulses, 4);

        // bounce on column 0 sample
        do_reset();
        base_pulses = pulses;
        step(3);
        bounce_en = 1'b1;
        step(3);
        bounce_en = 1'b0;
        step(1);    check("bounce_next_col", ColOut, 4'b1101);
        check("bounce_no_valid", key_valid, 0);
        step(SCAN); check("bounce_scan_resumes", ColOut, 4'b1011);
        key_ack = 1'b1;
        step(40);
        key_ack = 1'b0;
        check("bounce_no_pulse", pulses - base_pulses, 0);
        check("bounce_not_held", key_held, 0);

        // release before ack, index 8
        do_reset();
        press(2, 0);
        wait_valid("rel_before_ack_valid");
        press_en = 1'b0;
        step(20);
        check("valid_latched_after_release", key_valid, 1);
        check("held_latched_after_release", key_held, 1);
        do_ack();
        step(DEB - 1); check("rba_held_before_db", key_held, 1);
        step(1);       check("rba_held_drop", key_held, 0);

        // reset while VALID with the key still held
        do_reset();
        press(0, 2);
        wait_valid("pre_reset_valid");
        RST = 1'b1;
        step(1);
        check("midrst_valid", key_valid, 0);
        check("midrst_colout", ColOut, 4'b1110);
        check("midrst_held", key_held, 0);
        exp_q.push_back(4'd2);
        RST = 1'b0;
        step(20); check("redetect_early", key_valid, 0);
        step(1);  check("redetect_exact", key_valid, 1);
        do_ack();
        press_en = 1'b0;
        wait_held_low("redetect_release");

        check("scoreboard_empty", exp_q.size(), 0);
        check("total_pulses", pulses, 8);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
